qam_demap: RTL

QAM_DEMAP -- requirements
Module: qam_demap

---
 rtl/qam_demap.sv | 133 +++++++++++++
 1 files changed

// File: rtl/qam_demap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// qam_demap : hard-decision BPSK/QPSK/16QAM demapper, one bit out per handshake
// Revision  : 1.0
// ============================================================================
module qam_demap #(
   parameter int W   = 11,
   parameter int THR = 256
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [1:0]          mode,
   input  logic                valid_i,
   output logic                ready_i,
   input  logic signed [W-1:0] ar,
   input  logic signed [W-1:0] ai,
   output logic                valid_x,
   input  logic                ready_x,
   output logic                x,
   output logic                err
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [1:0] MODE_BPSK  = 2'd0;
   localparam logic [1:0] MODE_QPSK  = 2'd1;
   localparam logic [1:0] MODE_QAM16 = 2'd2;
   localparam logic [W:0] THR_EXT    = THR[W:0];

   state_t     state_q, state_d;
   logic [3:0] buf_q, buf_d;
   logic [2:0] bits_left_q, bits_left_d;
   logic       err_q, err_d;

   logic       accept;
   logic       consume;
   logic       s_ar, s_ai, m_ar, m_ai;
   logic [3:0] load_buf;
   logic [2:0] load_cnt;

   // Magnitude taken one bit wider so the most-negative sample negates cleanly.
   function automatic logic mag_bit(input logic signed [W-1:0] v);
      logic [W:0] ext;
      logic [W:0] mag;
      ext = {v[W-1], v};
      mag = ext[W] ? (~ext + 1'b1) : ext;
      return (mag >= THR_EXT);
   endfunction

   assign s_ar = ~ar[W-1];
   assign s_ai = ~ai[W-1];
   assign m_ar = mag_bit(ar);
   assign m_ai = mag_bit(ai);

   assign ready_i = !RST && ((state_q == IDLE) ||
                             ((state_q == SHIFT) && (bits_left_q == 3'd1) && ready_x));
   assign accept  = valid_i && ready_i;
   assign consume = valid_x && ready_x;

   assign valid_x = (state_q == SHIFT);
   assign x       = buf_q[3];
   assign err     = err_q;

   always_comb begin
      load_buf = 4'b0000;
      load_cnt = 3'd0;
      case (mode)
         MODE_BPSK: begin
            load_buf = {s_ar, 3'b000};
            load_cnt = 3'd1;
         end
         MODE_QPSK: begin
            load_buf = {s_ar, s_ai, 2'b00};
            load_cnt = 3'd2;
         end
         MODE_QAM16: begin
            load_buf = {s_ar, m_ar, s_ai, m_ai};
            load_cnt = 3'd4;
         end
         default: begin
            load_buf = 4'b0000;
            load_cnt = 3'd0;
         end
      endcase
   end

   // Consume first, then let an accepted symbol overwrite: gives bubble-free reload.
   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      bits_left_d = bits_left_q;
      err_d       = 1'b0;

      if (consume) begin
         buf_d       = {buf_q[2:0], 1'b0};
         bits_left_d = bits_left_q - 3'd1;
         if (bits_left_q == 3'd1) begin
            state_d = IDLE;
            buf_d   = 4'b0000;
         end
      end

      if (accept) begin
         if (load_cnt == 3'd0) begin
            err_d = 1'b1;
         end else begin
            state_d     = SHIFT;
            buf_d       = load_buf;
            bits_left_d = load_cnt;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         buf_q       <= 4'b0000;
         bits_left_q <= 3'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         bits_left_q <= bits_left_d;
         err_q       <= err_d;
      end
   end

endmodule
`default_nettype wire
